// File: rtl/flit_receiver.sv
// rtl/flit_receiver.sv - byte-to-flit assembler with idle timeout and optional XOR check (FLIT_CHECKSUM_EN)
// Bytes pack MSB-first into a flit, which is held until downstream accepts it.
module flit_receiver #(
  parameter int FLIT_BYTES     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [FLIT_BYTES*8-1:0] out_flit,
  input  logic                    out_ready,
  output logic                    err_checksum,
  output logic                    err_timeout,
  output logic                    busy
);

  localparam int CW = $clog2(FLIT_BYTES);
  localparam int IW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_BYTE  = CW'(FLIT_BYTES - 1);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idle_q, idle_d;
  logic [FLIT_BYTES*8-1:0] flit_q, flit_d;
  logic                    err_to_q, err_to_d;
  logic                    accept;
  logic                    sum_ok;
`ifdef FLIT_CHECKSUM_EN
  logic [7:0]              chk_q, chk_d;
  logic                    err_chk_q, err_chk_d;
`endif

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = idle_q;
    flit_d   = flit_q;
    err_to_d = 1'b0;
    sum_ok   = 1'b1;
`ifdef FLIT_CHECKSUM_EN
    chk_d     = chk_q;
    err_chk_d = 1'b0;
`endif
    if (state_q == COLLECT) begin
      if (accept) begin
        for (int i = 0; i < FLIT_BYTES; i++) begin
          if (cnt_q == CW'(i)) flit_d[(FLIT_BYTES-1-i)*8 +: 8] = in_data;
        end
        idle_d = '0;
`ifdef FLIT_CHECKSUM_EN
        // Running XOR restarts on the first byte of each flit.
        chk_d  = (cnt_q == '0) ? in_data : (chk_q ^ in_data);
        sum_ok = (chk_d == 8'h00);
`endif
        if (cnt_q == LAST_BYTE) begin
          cnt_d = '0;
          if (sum_ok) begin
            state_d = HOLD;
          end
`ifdef FLIT_CHECKSUM_EN
          else begin
            err_chk_d = 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (cnt_q != '0) begin
        if ((TIMEOUT_CYCLES > 0) && (idle_q == IDLE_LIMIT)) begin
          cnt_d    = '0;
          idle_d   = '0;
          err_to_d = 1'b1;
        end else if (TIMEOUT_CYCLES > 0) begin
          idle_d = idle_q + 1'b1;
        end
      end else begin
        idle_d = '0;
      end
    end else begin
      idle_d = '0;
      if (out_ready) state_d = COLLECT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      idle_q   <= '0;
      flit_q   <= '0;
      err_to_q <= 1'b0;
`ifdef FLIT_CHECKSUM_EN
      chk_q     <= 8'h00;
      err_chk_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      flit_q   <= flit_d;
      err_to_q <= err_to_d;
`ifdef FLIT_CHECKSUM_EN
      chk_q     <= chk_d;
      err_chk_q <= err_chk_d;
`endif
    end
  end

  // in_ready is gated by rst_n so upstream sees no acceptance while reset is held.
  assign in_ready    = rst_n && (state_q == COLLECT);
  assign out_valid   = (state_q == HOLD);
  assign out_flit    = flit_q;
  assign busy        = (cnt_q != '0) || (state_q == HOLD);
  assign err_timeout = err_to_q;
`ifdef FLIT_CHECKSUM_EN
  assign err_checksum = err_chk_q;
`else
  assign err_checksum = 1'b0;
`endif

endmodule

// File: doc/flit_receiver.md
FLIT_RECEIVER -- requirements
Module: flit_receiver

Interface
REQ-001 SHALL have parameter FLIT_BYTES, default 8, bytes per flit (legal range 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, inter-byte idle limit inside a partial flit (0 disables the timeout).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream byte valid.
REQ-006 SHALL have port in_data  input  8  upstream byte.
REQ-007 SHALL have port in_ready  output  1  byte accept strobe to upstream.
REQ-008 SHALL have port out_valid  output  1  assembled flit valid toward packet_buffer.
REQ-009 SHALL have port out_flit  output  FLIT_BYTES*8  assembled flit.
REQ-010 SHALL have port out_ready  input  1  packet_buffer accepts flit.
REQ-011 SHALL have port err_checksum  output  1  one-cycle pulse, flit dropped on checksum failure.
REQ-012 SHALL have port err_timeout  output  1  one-cycle pulse, partial flit discarded.
REQ-013 SHALL have port busy  output  1  high when byte count is nonzero or state is HOLD.

Function
REQ-014 SHALL implement two states: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 SHALL accept a byte only when in_valid && in_ready; the byte count increments by 1 per accept.
REQ-016 SHALL pack the first byte of a flit into out_flit[FLIT_BYTES*8-1 -: 8], subsequent bytes at descending positions (MSB first).
REQ-017 SHALL, on accepting byte FLIT_BYTES-1, clear the byte count and enter HOLD; out_valid rises the cycle after that accept (1-cycle latency).
REQ-018 SHALL hold out_flit and out_valid stable in HOLD until out_ready=1; the flit transfers on that edge and state returns to COLLECT.
REQ-019 SHALL NOT accept bytes in HOLD (no bypass); in_ready returns to 1 the cycle after the transfer.
REQ-020 SHALL run an idle counter in COLLECT while byte count>0: reset to 0 on every accept, increment otherwise.
REQ-021 SHALL, when TIMEOUT_CYCLES>0 and the idle counter equals TIMEOUT_CYCLES-1 with no accept that cycle, discard the partial flit (count=0) and pulse err_timeout the following cycle.
REQ-022 SHALL give a byte accept priority over timeout in the same cycle.
REQ-023 SHALL never time out with byte count 0 or in HOLD.
REQ-024 SHALL drive err_checksum and err_timeout each high for exactly one cycle per event, never simultaneously.

Reset
REQ-025 SHALL, on rst_n low, asynchronously force COLLECT, byte count 0, idle counter 0, out_flit 0, out_valid 0, err_checksum 0, err_timeout 0, busy 0; in_ready SHALL be 0 while rst_n is low.
REQ-026 SHALL discard any partial or held flit on reset without error pulses; in_ready SHALL be 1 in the first cycle after rst_n releases.

Configuration
REQ-027 SHALL, with FLIT_CHECKSUM_EN defined, require the XOR of all FLIT_BYTES bytes to be 0x00; on mismatch at the last byte, stay in COLLECT, assert no out_valid, and pulse err_checksum the next cycle.
REQ-028 SHALL, without FLIT_CHECKSUM_EN, forward every complete flit unchecked and tie err_checksum to 0.

Verification (bench: FLIT_BYTES=4, TIMEOUT_CYCLES=16, FLIT_CHECKSUM_EN defined)
REQ-029 SHALL cover: bytes 0x11,0x22,0x33,0x00 back-to-back, out_ready=1 -> out_valid one cycle after the 4th accept, out_flit=0x11223300, in_ready=0 for exactly 1 cycle.
REQ-030 SHALL cover: bytes 0x11,0x22,0x33,0x01 -> err_checksum pulse of 1 cycle, out_valid stays 0, next flit assembles normally.
REQ-031 SHALL cover: 2 bytes, then in_valid=0 for 16 cycles -> err_timeout pulse, busy=0; a 16th-cycle byte instead -> no timeout.
REQ-032 SHALL cover: flit complete, out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_flit stable, no bytes lost after release.
REQ-033 SHALL cover: rst_n pulsed low after 3 bytes -> all outputs 0 during reset, next 4 bytes form a fresh flit.
REQ-034 SHALL cover: rebuild without FLIT_CHECKSUM_EN, bytes 0x11,0x22,0x33,0x01 -> out_flit=0x11223301, err_checksum=0.
